// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, FSM states,
// and the ALUOp / ALUSrcB / PCSource select codes.
package cpu_pkg;

   localparam logic [3:0] OP_RTYPE = 4'd0;
   localparam logic [3:0] OP_ADDI  = 4'd1;
   localparam logic [3:0] OP_LW    = 4'd2;
   localparam logic [3:0] OP_SW    = 4'd3;
   localparam logic [3:0] OP_BEQ   = 4'd4;
   localparam logic [3:0] OP_BNE   = 4'd5;
   localparam logic [3:0] OP_JMP   = 4'd6;
   localparam logic [3:0] OP_HALT  = 4'd15;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_EXEC_R   = 4'd2;
   localparam logic [3:0] S_EXEC_I   = 4'd3;
   localparam logic [3:0] S_MEM_ADDR = 4'd4;
   localparam logic [3:0] S_MEM_RD   = 4'd5;
   localparam logic [3:0] S_MEM_WR   = 4'd6;
   localparam logic [3:0] S_WB_R     = 4'd7;
   localparam logic [3:0] S_WB_I     = 4'd8;
   localparam logic [3:0] S_WB_MEM   = 4'd9;
   localparam logic [3:0] S_BRANCH   = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;
   localparam logic [3:0] S_HALT     = 4'd12;
   localparam logic [3:0] S_TRAP     = 4'd13;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REGB = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BOFF = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   function automatic logic is_mem_state(input logic [3:0] s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle. The control unit is the master: it receives
// opcode/flags/memory-ready and drives every mux select and write enable.
interface multicycle_control_unit_if #(
   parameter int OPCODE_W = 4,
   parameter int ALUOP_W  = 2,
   parameter int CNT_W    = 16
);
   logic [OPCODE_W-1:0] opcode;
   logic                zero;
   logic                mem_ready;
   logic                pc_write;
   logic                ir_write;
   logic                iord;
   logic                mem_read;
   logic                mem_write;
   logic                reg_dst;
   logic                reg_write;
   logic                mem_to_reg;
   logic                alu_src_a;
   logic [1:0]          alu_src_b;
   logic [ALUOP_W-1:0]  alu_op;
   logic [1:0]          pc_source;
   logic                halted;
   logic                illegal_op;
   logic [CNT_W-1:0]    retired_count;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, ir_write, iord, mem_read, mem_write, reg_dst, reg_write,
             mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, halted,
             illegal_op, retired_count
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, ir_write, iord, mem_read, mem_write, reg_dst, reg_write,
             mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, halted,
             illegal_op, retired_count
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog: reloads on every state change, counts down while the
// current memory access is stalled, and flags a timeout on the last allowed cycle.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   input  logic i_wait,
   output logic o_timeout
);
   localparam int              W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [W-1:0]    LOAD = W'(MEM_TIMEOUT - 1);

   logic [W-1:0] r_remain;

   // Remaining count of MEM_TIMEOUT-1 means "no wait cycles elapsed yet".
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_remain <= LOAD;
      else if (i_load)
         r_remain <= LOAD;
      else if (i_wait && r_remain != '0)
         r_remain <= r_remain - W'(1);
   end

   assign o_timeout = i_wait && (r_remain == '0);
endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
// waits on memory ready with a timeout trap, and counts retired instructions.
module multicycle_control_unit
   import cpu_pkg::*;
#(
   parameter int OPCODE_W    = 4,
   parameter int ALUOP_W     = 2,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input logic                        i_clk,
   input logic                        i_rst,
   multicycle_control_unit_if.master  bus
);
   logic [3:0]          r_state;
   logic [3:0]          w_next;
   logic [CNT_W-1:0]    r_retired;
   logic                w_retire;
   logic                w_wait;
   logic                w_timeout;
   logic [OPCODE_W-1:0] w_op;

   assign w_op   = bus.opcode;
   assign w_wait = is_mem_state(r_state) && !bus.mem_ready;

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_load    (w_next != r_state),
      .i_wait    (w_wait),
      .o_timeout (w_timeout)
   );

   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      case (r_state)
         S_FETCH:    if (bus.mem_ready) w_next = S_DECODE;
                     else if (w_timeout) w_next = S_TRAP;
         S_DECODE: begin
            if      (w_op == OPCODE_W'(OP_RTYPE)) w_next = S_EXEC_R;
            else if (w_op == OPCODE_W'(OP_ADDI))  w_next = S_EXEC_I;
            else if (w_op == OPCODE_W'(OP_LW) || w_op == OPCODE_W'(OP_SW)) w_next = S_MEM_ADDR;
            else if (w_op == OPCODE_W'(OP_BEQ) || w_op == OPCODE_W'(OP_BNE)) w_next = S_BRANCH;
            else if (w_op == OPCODE_W'(OP_JMP))   w_next = S_JUMP;
            else if (w_op == OPCODE_W'(OP_HALT)) begin
               w_next   = S_HALT;
               w_retire = 1'b1;
            end
            else                                  w_next = S_TRAP;
         end
         S_EXEC_R:   w_next = S_WB_R;
         S_EXEC_I:   w_next = S_WB_I;
         S_MEM_ADDR: w_next = (w_op == OPCODE_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (bus.mem_ready) w_next = S_WB_MEM;
                     else if (w_timeout) w_next = S_TRAP;
         S_MEM_WR: begin
            if (bus.mem_ready) begin
               w_next   = S_FETCH;
               w_retire = 1'b1;
            end
            else if (w_timeout) w_next = S_TRAP;
         end
         S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         default:    w_next = r_state;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_FETCH;
         r_retired <= '0;
      end
      else begin
         r_state <= w_next;
         if (w_retire && r_retired != {CNT_W{1'b1}})
            r_retired <= r_retired + CNT_W'(1);
      end
   end

   // Reset forces every strobe low immediately, even though the reset state is FETCH.
   always_comb begin
      bus.pc_write   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.iord       = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = SRCB_REGB;
      bus.alu_op     = ALUOP_W'(ALUOP_ADD);
      bus.pc_source  = PCSRC_ALU;
      if (!i_rst) begin
         case (r_state)
            S_FETCH: begin
               bus.mem_read  = 1'b1;
               bus.alu_src_b = SRCB_ONE;
               bus.ir_write  = bus.mem_ready;
               bus.pc_write  = bus.mem_ready;
            end
            S_DECODE:   bus.alu_src_b = SRCB_BOFF;
            S_EXEC_R: begin
               bus.alu_src_a = 1'b1;
               bus.alu_op    = ALUOP_W'(ALUOP_FUNCT);
            end
            S_EXEC_I, S_MEM_ADDR: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
               bus.mem_read = 1'b1;
               bus.iord     = 1'b1;
            end
            S_MEM_WR: begin
               bus.mem_write = 1'b1;
               bus.iord      = 1'b1;
            end
            S_WB_R: begin
               bus.reg_write = 1'b1;
               bus.reg_dst   = 1'b1;
            end
            S_WB_I:     bus.reg_write = 1'b1;
            S_WB_MEM: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
               bus.alu_src_a = 1'b1;
               bus.alu_op    = ALUOP_W'(ALUOP_SUB);
               bus.pc_source = PCSRC_ALUOUT;
               bus.pc_write  = (w_op == OPCODE_W'(OP_BEQ)) ? bus.zero : !bus.zero;
            end
            S_JUMP: begin
               bus.pc_source = PCSRC_JUMP;
               bus.pc_write  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.halted        = !i_rst && (r_state == S_HALT);
   assign bus.illegal_op    = !i_rst && (r_state == S_TRAP);
   assign bus.retired_count = r_retired;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit: walks each instruction class
// cycle by cycle and compares the packed control word against hand-built constants.
module tb_multicycle_control_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   multicycle_control_unit_if bus ();

   multicycle_control_unit dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // {pcw, irw, iord, mrd, mwr, rdst, rw, m2r, srca, srcb[1:0], aluop[1:0], pcsrc[1:0]}
   logic [14:0] ctrl;
   assign ctrl = {bus.pc_write, bus.ir_write, bus.iord, bus.mem_read, bus.mem_write,
                  bus.reg_dst, bus.reg_write, bus.mem_to_reg, bus.alu_src_a,
                  bus.alu_src_b, bus.alu_op, bus.pc_source};

   localparam logic [14:0] C_ZERO    = 15'b000000000_00_00_00;
   localparam logic [14:0] C_FETCH   = 15'b110100000_01_00_00;
   localparam logic [14:0] C_FETCHW  = 15'b000100000_01_00_00;
   localparam logic [14:0] C_DECODE  = 15'b000000000_11_00_00;
   localparam logic [14:0] C_EXEC_R  = 15'b000000001_00_10_00;
   localparam logic [14:0] C_EXEC_I  = 15'b000000001_10_00_00;
   localparam logic [14:0] C_MADDR   = 15'b000000001_10_00_00;
   localparam logic [14:0] C_MEM_RD  = 15'b001100000_00_00_00;
   localparam logic [14:0] C_MEM_WR  = 15'b001010000_00_00_00;
   localparam logic [14:0] C_WB_R    = 15'b000001100_00_00_00;
   localparam logic [14:0] C_WB_I    = 15'b000000100_00_00_00;
   localparam logic [14:0] C_WB_MEM  = 15'b000000110_00_00_00;
   localparam logic [14:0] C_BR_TK   = 15'b100000001_00_01_01;
   localparam logic [14:0] C_BR_NT   = 15'b000000001_00_01_01;
   localparam logic [14:0] C_JUMP    = 15'b100000000_00_00_10;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Apply inputs for one cycle, check the control word mid-cycle, advance to the next.
   task automatic cyc(input string tag, input logic [3:0] op, input logic z,
                      input logic rdy, input logic [14:0] exp);
      bus.opcode    = op;
      bus.zero      = z;
      bus.mem_ready = rdy;
      #1;
      chk(tag, {17'd0, ctrl}, {17'd0, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_ctrl", {17'd0, ctrl}, 32'd0);
      chk("rst_halt", {31'd0, bus.halted}, 32'd0);
      chk("rst_ill", {31'd0, bus.illegal_op}, 32'd0);
      chk("rst_cnt", {16'd0, bus.retired_count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      bus.opcode    = 4'd0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;
      @(posedge clk);
      #1;
      do_reset();

      // R-type: 4 cycles
      cyc("r_f", 4'd0, 1'b0, 1'b1, C_FETCH);
      cyc("r_d", 4'd0, 1'b0, 1'b1, C_DECODE);
      cyc("r_x", 4'd0, 1'b0, 1'b1, C_EXEC_R);
      cyc("r_wb", 4'd0, 1'b0, 1'b1, C_WB_R);
      chk("r_cnt", {16'd0, bus.retired_count}, 32'd1);

      // LW with 3 stall cycles in MEM_RD: 8 cycles
      cyc("lw_f", 4'd2, 1'b0, 1'b1, C_FETCH);
      cyc("lw_d", 4'd2, 1'b0, 1'b1, C_DECODE);
      cyc("lw_a", 4'd2, 1'b0, 1'b1, C_MADDR);
      for (int i = 0; i < 3; i++) cyc("lw_rdw", 4'd2, 1'b0, 1'b0, C_MEM_RD);
      cyc("lw_rd", 4'd2, 1'b0, 1'b1, C_MEM_RD);
      chk("lw_cnt_mid", {16'd0, bus.retired_count}, 32'd1);
      cyc("lw_wb", 4'd2, 1'b0, 1'b1, C_WB_MEM);
      chk("lw_cnt", {16'd0, bus.retired_count}, 32'd2);

      // BEQ taken, BNE not taken (Zero=1 both)
      cyc("beq_f", 4'd4, 1'b1, 1'b1, C_FETCH);
      cyc("beq_d", 4'd4, 1'b1, 1'b1, C_DECODE);
      cyc("beq_b", 4'd4, 1'b1, 1'b1, C_BR_TK);
      cyc("bne_f", 4'd5, 1'b1, 1'b1, C_FETCH);
      cyc("bne_d", 4'd5, 1'b1, 1'b1, C_DECODE);
      cyc("bne_b", 4'd5, 1'b1, 1'b1, C_BR_NT);
      chk("br_cnt", {16'd0, bus.retired_count}, 32'd4);

      // ADDI, SW, JMP
      cyc("ai_f", 4'd1, 1'b0, 1'b1, C_FETCH);
      cyc("ai_d", 4'd1, 1'b0, 1'b1, C_DECODE);
      cyc("ai_x", 4'd1, 1'b0, 1'b1, C_EXEC_I);
      cyc("ai_wb", 4'd1, 1'b0, 1'b1, C_WB_I);
      cyc("sw_f", 4'd3, 1'b0, 1'b1, C_FETCH);
      cyc("sw_d", 4'd3, 1'b0, 1'b1, C_DECODE);
      cyc("sw_a", 4'd3, 1'b0, 1'b1, C_MADDR);
      cyc("sw_w", 4'd3, 1'b0, 1'b1, C_MEM_WR);
      cyc("j_f", 4'd6, 1'b0, 1'b1, C_FETCH);
      cyc("j_d", 4'd6, 1'b0, 1'b1, C_DECODE);
      cyc("j_j", 4'd6, 1'b0, 1'b1, C_JUMP);
      chk("j_cnt", {16'd0, bus.retired_count}, 32'd7);

      // HALT retires on entry and is terminal
      cyc("h_f", 4'd15, 1'b0, 1'b1, C_FETCH);
      cyc("h_d", 4'd15, 1'b0, 1'b1, C_DECODE);
      chk("h_halt", {31'd0, bus.halted}, 32'd1);
      chk("h_cnt", {16'd0, bus.retired_count}, 32'd8);
      for (int i = 0; i < 3; i++) cyc("h_hold", 4'd0, 1'b1, 1'b1, C_ZERO);
      chk("h_halt2", {31'd0, bus.halted}, 32'd1);
      chk("h_cnt2", {16'd0, bus.retired_count}, 32'd8);
      do_reset();

      // Reset mid-instruction (in EXEC_R) clears outputs without a clock edge
      cyc("m_f", 4'd0, 1'b0, 1'b1, C_FETCH);
      cyc("m_d", 4'd0, 1'b0, 1'b1, C_DECODE);
      do_reset();
      cyc("m_f2", 4'd0, 1'b0, 1'b1, C_FETCH);

      // Illegal opcode traps after DECODE
      cyc("il_d", 4'd9, 1'b0, 1'b1, C_DECODE);
      for (int i = 0; i < 10; i++) cyc("il_trap", 4'd9, 1'b0, 1'b1, C_ZERO);
      chk("il_flag", {31'd0, bus.illegal_op}, 32'd1);
      chk("il_cnt", {16'd0, bus.retired_count}, 32'd0);
      do_reset();

      // FETCH timeout: 15 stalled FETCH cycles then TRAP, no IRWrite
      for (int i = 0; i < 15; i++) cyc("to_f", 4'd0, 1'b0, 1'b0, C_FETCHW);
      chk("to_ill", {31'd0, bus.illegal_op}, 32'd1);
      cyc("to_trap", 4'd0, 1'b0, 1'b1, C_ZERO);
      do_reset();

      // MemReady on the final allowed cycle of MEM_RD wins over the timeout
      cyc("lb_f", 4'd2, 1'b0, 1'b1, C_FETCH);
      cyc("lb_d", 4'd2, 1'b0, 1'b1, C_DECODE);
      cyc("lb_a", 4'd2, 1'b0, 1'b1, C_MADDR);
      for (int i = 0; i < 14; i++) cyc("lb_rdw", 4'd2, 1'b0, 1'b0, C_MEM_RD);
      cyc("lb_rd", 4'd2, 1'b0, 1'b1, C_MEM_RD);
      cyc("lb_wb", 4'd2, 1'b0, 1'b1, C_WB_MEM);
      chk("lb_cnt", {16'd0, bus.retired_count}, 32'd1);

      // SW timing out in MEM_WR traps without retiring
      cyc("st_f", 4'd3, 1'b0, 1'b1, C_FETCH);
      cyc("st_d", 4'd3, 1'b0, 1'b1, C_DECODE);
      cyc("st_a", 4'd3, 1'b0, 1'b1, C_MADDR);
      for (int i = 0; i < 15; i++) cyc("st_w", 4'd3, 1'b0, 1'b0, C_MEM_WR);
      cyc("st_trap", 4'd3, 1'b0, 1'b1, C_ZERO);
      chk("st_ill", {31'd0, bus.illegal_op}, 32'd1);
      chk("st_cnt", {16'd0, bus.retired_count}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle control FSM; successor to the single-cycle ControlUnit in the 16-bit CPU.
- Sequences each instruction over several cycles through FETCH / DECODE / EXECUTE / MEM / WRITEBACK.
- Waits on a memory-ready handshake and traps on a memory timeout or an illegal opcode.
- Drives the multi-cycle Datapath mux selects and write enables, and keeps a retired-instruction counter.

Parameters:
- OPCODE_W, 4, opcode width.
- ALUOP_W, 2, ALUOp width.
- CNT_W, 16, retired-instruction counter width.
- MEM_TIMEOUT, 15, maximum cycles a memory state waits for MemReady before trapping (≥1).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Opcode  in  OPCODE_W  opcode from the instruction register.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory access completes this cycle.
- PCWrite  out  1  PC register load enable.
- IRWrite  out  1  instruction register load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead, MemWrite  out  1 each  memory strobes.
- RegDst  out  1  destination register select: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write enable.
- MemToReg  out  1  write-back source: 1 = MDR.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = regA.
- ALUSrcB  out  2  ALU B input: 00 regB, 01 const 1, 10 imm, 11 branch offset.
- ALUOp  out  ALUOP_W  00 add, 01 sub, 10 funct.
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target.
- Halted  out  1  sticky, set in HALT.
- IllegalOp  out  1  sticky, set in TRAP.
- RetiredCount  out  CNT_W  count of completed instructions.

Behaviour:
- Opcodes, fixed: RTYPE=0, ADDI=1, LW=2, SW=3, BEQ=4, BNE=5, JMP=6, HALT=15; all others are illegal.
- Reset, asynchronous: state=FETCH, all strobes 0, ALUSrcB=00, ALUOp=00, PCSource=00, Halted=0, IllegalOp=0, RetiredCount=0, wait counter=0. Reset mid-instruction aborts the instruction with no write.
- Outputs are decoded combinationally from the state. PCWrite and IRWrite also depend combinationally on MemReady and Zero, as noted per state.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite = PCWrite = MemReady.
  - Advance to DECODE when MemReady=1, else stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (computes the branch target).
  - Next state: RTYPE→EXEC_R; ADDI→EXEC_I; LW/SW→MEM_ADDR; BEQ/BNE→BRANCH; JMP→JUMP; HALT→HALT; else TRAP.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → WB_R.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → WB_I.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → MEM_RD if LW, MEM_WR if SW.
- MEM_RD: MemRead=1, IorD=1 → WB_MEM on MemReady.
- MEM_WR: MemWrite=1, IorD=1 → FETCH on MemReady; the instruction retires.
- WB_R: RegWrite=1, RegDst=1, MemToReg=0 → FETCH.
- WB_I: RegWrite=1, RegDst=0, MemToReg=0 → FETCH.
- WB_MEM: RegWrite=1, RegDst=0, MemToReg=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01.
  - PCWrite = Zero for BEQ, !Zero for BNE.
  - → FETCH.
- JUMP: PCSource=10, PCWrite=1 → FETCH.
- HALT, TRAP: terminal. All strobes 0. Only Reset leaves either state.
- Memory wait (FETCH, MEM_RD, MEM_WR):
  - The wait counter clears on entry to the state and increments each cycle MemReady=0.
  - If MemReady=0 and counter==MEM_TIMEOUT-1 → TRAP with no write. MemReady=1 on that same cycle wins.
- RetiredCount:
  - Increments on the transition out of WB_R, WB_I, WB_MEM, MEM_WR, BRANCH and JUMP, and on the transition into HALT.
  - Saturates at 2^CNT_W-1.
  - A trapped instruction does not count.
- Cycle counts with MemReady held at 1: R/ADDI 4, LW 5, SW 4, BEQ/BNE 3, JMP 3.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams;
  - state encoding, one localparam per state, 4-bit;
  - ALUOp, ALUSrcB and PCSource encodings.
- One sub-module, mem_wait_timer: a parametrised down-counter with load on state entry and a timeout output.
- The FSM state register, output decode and retire counter stay in the top module.

Test Plan:
- Reset held, then RTYPE (Opcode=0), MemReady=1 → FETCH, DECODE, EXEC_R, WB_R. RegWrite=1 and RegDst=1 in cycle 4; RetiredCount=1.
- LW with MemReady low 3 cycles in MEM_RD → MemRead=1 and IorD=1 held 4 cycles. Then WB_MEM with MemToReg=1; total 8 cycles; RetiredCount increments by 1.
- BEQ with Zero=1, then BNE with Zero=1 → PCWrite=1 with PCSource=01 in the first BRANCH; PCWrite=0 in the second; both retire.
- Opcode=9 → TRAP after DECODE, IllegalOp=1, all strobes 0 for 10 further cycles; RetiredCount unchanged.
- MemReady held 0 in FETCH with MEM_TIMEOUT=15 → TRAP entered exactly 15 cycles after FETCH entry; no IRWrite pulse.
- HALT after 3 instructions → Halted=1, RetiredCount=4. Assert Reset mid-state → all outputs return to their reset values immediately, without waiting for a Clock edge.
